bomberman_move_ctrl: RTL

Sequencer for bomberman sprite motion. It turns held direction buttons and a frame-rate move tick into one-pixel step commands for the position datapath. Before each step it queries the collision comparator for the chosen direction over a req/ack handshake, and it only issues the step if that direction is clear. It sits between the top module (buttons, tick, game_over), the collision comparator and the sprite position register.

---
 rtl/bomberman_move_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/bomberman_move_ctrl.sv
// bomberman_move_ctrl: button/tick to collision-checked one-pixel steps; `define MOVE_STATS_EN adds step/blocked counters
module bomberman_move_ctrl #(
  parameter int TICKS_PER_STEP = 1,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        L,
  input  logic        R,
  input  logic        U,
  input  logic        D,
  input  logic        move_tick,
  input  logic        game_over,
  output logic        chk_req,
  output logic [1:0]  chk_dir,
  input  logic        chk_ack,
  input  logic        chk_blocked,
  output logic        step_valid,
  output logic [1:0]  step_dir,
  input  logic        step_ready,
  output logic [1:0]  facing,
  output logic        moving,
`ifdef MOVE_STATS_EN
  output logic [15:0] step_count,
  output logic [15:0] blocked_count,
`endif
  output logic        timeout_err
);
  localparam int TW = $clog2(CHK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, CHECK, STEP} state_t;
  state_t state, state_n;
  logic [3:0] tick_cnt, tick_n, btns;
  logic [TW-1:0] to_cnt, to_n;
  logic [1:0] dir, dir_q, dir_n, facing_n;
  logic held, tick_hit, to_hit, terr_n;
  assign btns = {D, U, R, L};
  assign held = |btns;
  assign dir = L ? 2'd0 : R ? 2'd1 : U ? 2'd2 : 2'd3;
  assign tick_hit = tick_cnt == 4'(TICKS_PER_STEP - 1);
  assign to_hit = to_cnt == TW'(CHK_TIMEOUT - 1);
  assign chk_req = state == CHECK;
  assign step_valid = state == STEP;
  assign moving = chk_req | step_valid;
  assign chk_dir = dir_q;
  assign step_dir = dir_q;
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    to_n = to_cnt;
    dir_n = dir_q;
    facing_n = facing;
    terr_n = timeout_err;
    case (state)
      IDLE:
        if (game_over || !held) tick_n = '0;
        else if (move_tick && tick_hit) begin
          tick_n = '0;
          to_n = '0;
          dir_n = dir;
          facing_n = dir;
          state_n = CHECK;
        end else if (move_tick) tick_n = tick_cnt + 4'd1;
      CHECK:
        if (chk_ack) state_n = (chk_blocked || !btns[dir_q] || game_over) ? IDLE : STEP;
        else if (to_hit) begin
          terr_n = 1'b1;
          state_n = IDLE;
        end else to_n = to_cnt + 1'b1;
      STEP: state_n = step_ready ? IDLE : STEP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      to_cnt <= '0;
      dir_q <= 2'd0;
      facing <= 2'd3;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      tick_cnt <= tick_n;
      to_cnt <= to_n;
      dir_q <= dir_n;
      facing <= facing_n;
      timeout_err <= terr_n;
    end
  end
`ifdef MOVE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      step_count <= '0;
      blocked_count <= '0;
    end else begin
      if (step_valid && step_ready && step_count != 16'hFFFF) step_count <= step_count + 16'd1;
      if (chk_req && chk_ack && chk_blocked && blocked_count != 16'hFFFF) blocked_count <= blocked_count + 16'd1;
    end
  end
`endif
endmodule
